// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: pipeline writes win, multi-cycle results queue in a FIFO.
// Optional macro WB_ARB_SCOREBOARD_EN enables the per-register pending-write busy decode.
module wb_arbiter #(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ex_wen,
  input  logic       ex_src,
  input  logic [7:0] ex_s,
  input  logic [7:0] ex_add,
  input  logic [2:0] ex_rd,
  input  logic       mc_valid,
  output logic       mc_ready,
  input  logic [2:0] mc_rd,
  input  logic [7:0] mc_data,
  output logic       rf_we,
  output logic [2:0] rf_waddr,
  output logic [7:0] rf_wdata,
  output logic       stall,
  output logic [7:0] busy
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_DRAIN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [2:0]      mem_rd_q   [FIFO_DEPTH];
  logic [2:0]      mem_rd_d   [FIFO_DEPTH];
  logic [7:0]      mem_data_q [FIFO_DEPTH];
  logic [7:0]      mem_data_d [FIFO_DEPTH];
  logic            rf_we_q, rf_we_d;
  logic [2:0]      rf_waddr_q, rf_waddr_d;
  logic [7:0]      rf_wdata_q, rf_wdata_d;
  logic            push_s, pop_s, lose_s, empty_s;

  // Only entries present before this edge can be granted, so a push never bypasses.
  assign empty_s  = (count_q == CW'(0));
  assign mc_ready = (count_q != CW'(FIFO_DEPTH));
  assign push_s   = mc_valid && mc_ready;
  assign pop_s    = !ex_wen && !empty_s;
  assign lose_s   = ex_wen && !empty_s;

  // Datapath: FIFO storage, pointers, occupancy and registered write port.
  always_comb begin
    mem_rd_d   = mem_rd_q;
    mem_data_d = mem_data_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (push_s) begin
      mem_rd_d[wr_ptr_q]   = mc_rd;
      mem_data_d[wr_ptr_q] = mc_data;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (ex_wen) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = ex_rd;
      rf_wdata_d = ex_src ? ex_add : ex_s;
    end else if (pop_s) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = mem_rd_q[rd_ptr_q];
      rf_wdata_d = mem_data_q[rd_ptr_q];
      rd_ptr_d   = rd_ptr_q + PW'(1);
    end else begin
      rf_we_d = 1'b0;
    end
    if (push_s && !pop_s) begin
      count_d = count_q + CW'(1);
    end else if (pop_s && !push_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Starvation counter and RUN/DRAIN sequencing.
  always_comb begin
    state_d  = state_q;
    starve_d = '0;
    if (lose_s) begin
      starve_d = (starve_q == SW'(STARVE_MAX)) ? starve_q : starve_q + SW'(1);
    end else begin
      starve_d = '0;
    end
    case (state_q)
      ST_RUN: begin
        if (lose_s && (starve_q == SW'(STARVE_MAX - 1))) state_d = ST_DRAIN;
        else state_d = ST_RUN;
      end
      ST_DRAIN: begin
        if (count_d == CW'(0)) begin
          state_d  = ST_RUN;
          starve_d = '0;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State registers; reset discards any queued entries.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      starve_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 3'd0;
      rf_wdata_q <= 8'h00;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_rd_q[i]   <= 3'd0;
        mem_data_q[i] <= 8'h00;
      end
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      mem_rd_q   <= mem_rd_d;
      mem_data_q <= mem_data_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign stall    = (state_q == ST_DRAIN);

`ifdef WB_ARB_SCOREBOARD_EN
  logic [7:0]    busy_s;
  logic [PW-1:0] off_s;

  // An entry is valid when its distance from the read pointer is below the occupancy.
  always_comb begin
    busy_s = 8'h00;
    off_s  = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      off_s = PW'(i) - rd_ptr_q;
      if (CW'(off_s) < count_q) busy_s[mem_rd_q[i]] = 1'b1;
      else busy_s = busy_s;
    end
  end

  assign busy = busy_s;
`else
  assign busy = 8'h00;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter: reset, pipeline path, queue, starvation, reset mid-drain.
module tb_wb_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ex_wen = 1'b0, ex_src = 1'b0, mc_valid = 1'b0;
  logic [7:0] ex_s = 8'h00, ex_add = 8'h00, mc_data = 8'h00;
  logic [2:0] ex_rd = 3'd0, mc_rd = 3'd0;
  logic       mc_ready, rf_we, stall;
  logic [2:0] rf_waddr;
  logic [7:0] rf_wdata, busy;
  int checks = 0, failures = 0;

`ifdef WB_ARB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  wb_arbiter #(.FIFO_DEPTH(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst), .ex_wen(ex_wen), .ex_src(ex_src), .ex_s(ex_s), .ex_add(ex_add),
    .ex_rd(ex_rd), .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_rd(mc_rd), .mc_data(mc_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .stall(stall), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_busy(input logic [7:0] b);
    return SB ? b : 8'h00;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ex_wen = 1'($urandom); ex_src = 1'($urandom); ex_s = 8'($urandom); ex_add = 8'($urandom);
      ex_rd = 3'($urandom); mc_valid = 1'($urandom); mc_rd = 3'($urandom); mc_data = 8'($urandom);
      step();
      checks++;
      if ({rf_we, rf_waddr, rf_wdata, stall, busy, mc_ready} !== {1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 1'b1}) begin
        failures++;
        $display("FAIL reset_hold got we=%b a=%0d d=%h st=%b busy=%h rdy=%b", rf_we, rf_waddr, rf_wdata, stall, busy, mc_ready);
      end
    end
    ex_wen = 1'b0; mc_valid = 1'b0; ex_src = 1'b0; ex_s = 8'h00; ex_add = 8'h00; ex_rd = 3'd0;
    rst = 1'b1;
    step(); step();
    checks++;
    if ({rf_we, stall, busy, mc_ready} !== {1'b0, 1'b0, 8'h00, 1'b1}) begin
      failures++;
      $display("FAIL reset_idle got we=%b st=%b busy=%h rdy=%b expected 0 0 00 1", rf_we, stall, busy, mc_ready);
    end
  endtask

  task automatic test_pipeline();
    ex_wen = 1'b1; ex_rd = 3'd5; ex_src = 1'b0; ex_s = 8'hA5; ex_add = 8'h3C;
    step();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 3'd5, 8'hA5}) begin
      failures++;
      $display("FAIL pipe_s got we=%b a=%0d d=%h expected 1 5 a5", rf_we, rf_waddr, rf_wdata);
    end
    ex_src = 1'b1;
    step();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 3'd5, 8'h3C}) begin
      failures++;
      $display("FAIL pipe_add got we=%b a=%0d d=%h expected 1 5 3c", rf_we, rf_waddr, rf_wdata);
    end
    ex_wen = 1'b0; ex_rd = 3'd1; ex_add = 8'hFF;
    step();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 3'd5, 8'h3C}) begin
      failures++;
      $display("FAIL pipe_hold got we=%b a=%0d d=%h expected 0 5 3c", rf_we, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_idle_grant();
    mc_valid = 1'b1; mc_rd = 3'd2; mc_data = 8'h77;
    step();
    mc_valid = 1'b0;
    checks++;
    if ({rf_we, busy} !== {1'b0, exp_busy(8'h04)}) begin
      failures++;
      $display("FAIL idle_push got we=%b busy=%h expected 0 %h", rf_we, busy, exp_busy(8'h04));
    end
    step();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, busy, mc_ready} !== {1'b1, 3'd2, 8'h77, 8'h00, 1'b1}) begin
      failures++;
      $display("FAIL idle_pop got we=%b a=%0d d=%h busy=%h rdy=%b expected 1 2 77 00 1", rf_we, rf_waddr, rf_wdata, busy, mc_ready);
    end
  endtask

  task automatic test_full_queue();
    ex_wen = 1'b1; ex_src = 1'b0; ex_rd = 3'd1; ex_s = 8'h11;
    mc_valid = 1'b1; mc_rd = 3'd3; mc_data = 8'h33;
    step();
    mc_rd = 3'd4; mc_data = 8'h44;
    step();
    checks++;
    if ({mc_ready, busy, rf_we, rf_waddr, rf_wdata} !== {1'b0, exp_busy(8'h18), 1'b1, 3'd1, 8'h11}) begin
      failures++;
      $display("FAIL full_ready got rdy=%b busy=%h we=%b a=%0d d=%h", mc_ready, busy, rf_we, rf_waddr, rf_wdata);
    end
    ex_wen = 1'b0; mc_rd = 3'd6; mc_data = 8'h66;
    step();
    mc_valid = 1'b0;
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, mc_ready, busy} !== {1'b1, 3'd3, 8'h33, 1'b1, exp_busy(8'h10)}) begin
      failures++;
      $display("FAIL full_pop1 got we=%b a=%0d d=%h rdy=%b busy=%h", rf_we, rf_waddr, rf_wdata, mc_ready, busy);
    end
    step();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, busy} !== {1'b1, 3'd4, 8'h44, 8'h00}) begin
      failures++;
      $display("FAIL full_pop2 got we=%b a=%0d d=%h busy=%h expected 1 4 44 00", rf_we, rf_waddr, rf_wdata, busy);
    end
    step();
    checks++;
    if ({rf_we, stall} !== {1'b0, 1'b0}) begin
      failures++;
      $display("FAIL full_no_third got we=%b st=%b expected 0 0", rf_we, stall);
    end
  endtask

  task automatic test_starvation();
    ex_wen = 1'b1; ex_rd = 3'd0; ex_s = 8'h01;
    mc_valid = 1'b1; mc_rd = 3'd7; mc_data = 8'h5A;
    step();
    mc_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL starve_3loss got stall=%b expected 0", stall);
    end
    step();
    checks++;
    if ({stall, busy} !== {1'b1, exp_busy(8'h80)}) begin
      failures++;
      $display("FAIL starve_4loss got stall=%b busy=%h expected 1 %h", stall, busy, exp_busy(8'h80));
    end
    ex_wen = 1'b0;
    step();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, stall} !== {1'b1, 3'd7, 8'h5A, 1'b0}) begin
      failures++;
      $display("FAIL starve_drain got we=%b a=%0d d=%h st=%b expected 1 7 5a 0", rf_we, rf_waddr, rf_wdata, stall);
    end
  endtask

  task automatic test_reset_drain();
    ex_wen = 1'b1; ex_rd = 3'd0; ex_s = 8'h02;
    mc_valid = 1'b1; mc_rd = 3'd1; mc_data = 8'hB1;
    step();
    mc_rd = 3'd6; mc_data = 8'hB6;
    step();
    mc_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if ({stall, mc_ready, busy} !== {1'b1, 1'b0, exp_busy(8'h42)}) begin
      failures++;
      $display("FAIL rdrain_setup got st=%b rdy=%b busy=%h", stall, mc_ready, busy);
    end
    ex_wen = 1'b0;
    rst = 1'b0;
    #2;
    checks++;
    if ({stall, busy, mc_ready, rf_we} !== {1'b0, 8'h00, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL rdrain_rst got st=%b busy=%h rdy=%b we=%b expected 0 00 1 0", stall, busy, mc_ready, rf_we);
    end
    step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({rf_we, stall} !== {1'b0, 1'b0}) begin
        failures++;
        $display("FAIL rdrain_nowrite cycle %0d got we=%b st=%b expected 0 0", i, rf_we, stall);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pipeline();
    test_idle_grant();
    test_full_queue();
    test_starvation();
    test_reset_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback-port arbiter and sequencer for the 4-stage pipeline's 8-entry, 8-bit register file. It shares the single register-file write port between two requesters: the in-order EX/WB pipeline stream and a multi-cycle unit (load/multiply) that completes out of band. Multi-cycle results queue in a small FIFO, and the block stalls the front end when that queue is starved. It sits between the EX/WB pipeline register outputs and the register-file write port.

## Interface
- FIFO_DEPTH, 2: multi-cycle result queue depth; a power of two, at least 2.
- STARVE_MAX, 4: consecutive lost arbitration cycles at the FIFO head that force DRAIN; at least 1.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset; one clock.
- ex_wen  in  1  pipeline writeback enable (EX/WB regwrite).
- ex_src  in  1  pipeline data select: 1 selects ex_add, 0 selects ex_s.
- ex_s  in  8  pipeline ALU result.
- ex_add  in  8  pipeline address/memory result.
- ex_rd  in  3  pipeline destination register.
- mc_valid  in  1  multi-cycle result offered.
- mc_ready  out  1  queue can accept; equals FIFO not full.
- mc_rd  in  3  multi-cycle destination register.
- mc_data  in  8  multi-cycle result.
- rf_we  out  1  register-file write enable, registered.
- rf_waddr  out  3  register-file write address, registered.
- rf_wdata  out  8  register-file write data, registered.
- stall  out  1  front-end stall request, registered.
- busy  out  8  per-register pending-write scoreboard.

## Operation
- A push occurs when mc_valid && mc_ready. mc_ready is derived from the occupancy count only: when full, there is no push even if a pop occurs in the same cycle.
- Arbitration, once per cycle:
  - ex_wen=1 always wins. rf_* is loaded with ex_rd and the selected data.
  - Otherwise, if the FIFO is non-empty, the head is popped into rf_*.
  - Otherwise rf_we=0. rf_waddr and rf_wdata hold their previous values.
- The FIFO has no bypass. An entry pushed in cycle t is eligible for grant no earlier than cycle t+1.
- Starvation counter, width clog2(STARVE_MAX+1):
  - Increments each cycle the FIFO is non-empty and the head loses to ex_wen.
  - Clears when the head is granted or the FIFO is empty.
- FSM states:
  - RUN: stall=0. Moves to DRAIN when the head loses while the counter equals STARVE_MAX-1.
  - DRAIN: stall=1. The front end then guarantees ex_wen=0 from the second cycle of stall onward. Pipeline priority is still honoured if ex_wen=1 arrives. Moves to RUN in the cycle after the last FIFO entry is popped, and the counter clears.
- Push and pop in the same cycle leave the count unchanged. The pointers wrap modulo FIFO_DEPTH.
- busy[i]=1 when any valid FIFO entry targets register i. It is decoded from FIFO state only, with no combinational path from inputs. The issue stage must not issue a write or read to a busy register, which prevents WAW/RAW hazards against the queue.

## Timing
- Pipeline write latency: inputs sampled at edge t appear on rf_* immediately after edge t. This is the same registered stage as EX/WB.
- Multi-cycle write latency: at least 1 cycle from push to rf_we, plus the cycles lost to pipeline writes.
- stall rises at most STARVE_MAX+1 cycles after the head first becomes eligible.
- Reset values:
  - rf_we=0, rf_waddr=0, rf_wdata=0, stall=0, busy=0.
  - mc_ready=1.
  - FIFO emptied, counter=0, state RUN.
- Reset asserted mid-DRAIN or with queued entries discards those entries. No write is issued for them.

## Configuration
- WB_ARB_SCOREBOARD_EN defined: busy is decoded as above.
- WB_ARB_SCOREBOARD_EN undefined: busy is tied to 8'h00 and the decode logic is removed. Arbitration, FIFO and FSM are unchanged.

## Test plan
- Reset: hold rst=0 with random inputs -> rf_we=0, rf_waddr=0, rf_wdata=0, stall=0, busy=0, mc_ready=1. Release; the first write appears only after the first request.
- Pipeline only: ex_wen=1, ex_rd=5, ex_src=0, ex_s=8'hA5 -> next edge rf_we=1, rf_waddr=5, rf_wdata=8'hA5. With ex_src=1, ex_add=8'h3C -> rf_wdata=8'h3C.
- Idle-port grant: push mc_rd=2, mc_data=8'h77 with ex_wen=0 -> busy=8'h04 after the push edge; next edge rf_we=1, rf_waddr=2, rf_wdata=8'h77; busy=0.
- Full queue: push 2 entries while ex_wen=1 continuously -> mc_ready=0. A third mc_valid is not accepted, even on a cycle where a pop occurs.
- Starvation: 1 entry queued, ex_wen=1 for 4 cycles -> stall=1 after the 4th loss. Drop ex_wen -> the entry is written, then stall=0 the cycle after the pop.
- Reset mid-DRAIN: 2 entries queued with stall=1, pulse rst=0 -> stall=0, busy=0, mc_ready=1, and no write is issued for the discarded entries.
